timer_responder: RTL and testbench
==================================

Name: timer_responder

Overview:
- Memory-mapped countdown timer on the CPU data bus.
- It is a bus responder: it decodes `m_data_addr`/`m_data_wdata`/`m_data_byteen` traffic that the bridge routes to window 0x7F00–0x7F0B, returns read data, and raises one `HWINT` line.
- Provides one-shot and periodic interrupt generation.
- COUNT is read-only from the bus.

Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- addr  in  30  word address bits [31:2] from bridge; only addr[3:2] decoded (bridge guarantees window hit)
- we  in  1  bus write strobe for this device
- byteen  in  4  byte enables; a write takes effect only when byteen == 4'b1111
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr
- irq  out  1  interrupt request to HWINT[n]

Behaviour:
- Register map (addr[3:2]):
  - 0 = CTRL: bits [3:0] stored, bits [31:4] read 0. bit0 EN, bits[2:1] MODE, bit3 IM (interrupt mask, 1 = enabled).
  - 1 = PRESET (32 bits).
  - 2 = COUNT (32 bits, read-only).
  - 3 = reserved: reads 0, writes ignored.
- Reads: rdata is combinational, same cycle; no side effects.
- Writes:
  - Registered at the rising edge when we=1 and byteen=4'b1111.
  - Partial byteen writes are ignored entirely.
  - Writes to COUNT are ignored.
- irq = IM & irq_flag (combinational from registers).
- Reset (reset==0 at edge): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Hence rdata reflects zeros and irq=0. Reset overrides a concurrent bus write and any mid-count state.
- FSM: IDLE, LOAD, CNT, INT.
  - IDLE: if EN → LOAD; else stay. COUNT holds.
  - LOAD: COUNT<=PRESET; → CNT.
  - CNT:
    - if !EN → IDLE, COUNT holds.
    - else if COUNT>1 → COUNT<=COUNT−1.
    - else (COUNT==1 or 0) → COUNT<=0, irq_flag<=1, → INT.
  - INT:
    - MODE==1 (periodic): irq_flag<=0, EN unchanged, → IDLE. irq is a 1-cycle pulse; the FSM then reloads automatically.
    - MODE 0/2/3 (one-shot): CTRL.EN<=0, → IDLE; irq_flag stays 1.
- CTRL write:
  - Forces state<=IDLE and irq_flag<=0 at the same edge.
  - Overrides any FSM update of CTRL/state/irq_flag in that cycle (bus wins).
  - COUNT is unchanged.
- PRESET write: updates PRESET only. It does not touch the FSM or irq_flag, and takes effect at the next LOAD.
- Cycle timing with PRESET=P≥1 and CTRL written at edge 0:
  - LOAD at edge 1, COUNT=P at edge 2.
  - COUNT reaches 0 and irq rises at edge P+2.
  - INT is handled at edge P+3.
  - Periodic repeat interval is P+3 cycles.
- P=0 behaves as P=1 timing-wise, but COUNT reads 0 throughout.

Test Plan:
- Reset low 2 cycles with `we` pulsed writing CTRL=0xF → after release: CTRL/PRESET/COUNT read 0, irq=0.
- PRESET=3, then CTRL=0x9 (EN, mode0, IM) at edge 0 → COUNT reads 3,2,1,0 after edges 2,3,4,5; irq=1 from edge 5 and held; CTRL reads 0x8 after edge 6; state stays IDLE.
- Same as above with CTRL=0xB (mode1) → irq high exactly one cycle (edges 5–6); COUNT reloads 3 at edge 8; second irq pulse at edge 11.
- Mode0 irq pending, write CTRL=0x0 → irq=0 next cycle; write CTRL=0x1 (IM=0) and let it expire → irq stays 0 while irq_flag is set; then set IM via CTRL write → flag cleared, irq stays 0.
- Counting from PRESET=10, write CTRL with EN=0 mid-count (COUNT=6) → COUNT frozen at 6, no irq.
- Write COUNT=0x1234, write PRESET with byteen=4'b0011, read addr[3:2]=3 → COUNT and PRESET unchanged, reserved read returns 0.

Source files
------------

// File: rtl/timer_responder.sv
// rtl/timer_responder.sv - memory-mapped countdown timer bus responder with one interrupt line
//
// Countdown timer with one-shot and periodic modes. It has four word registers,
// selected by addr[1:0] (byte address bits [3:2]):
//   0 CTRL   [3:0] = {IM, MODE[1:0], EN}
//   1 PRESET
//   2 COUNT  (read-only)
//   3 reserved
// Ports:
//   clk     system clock
//   reset   synchronous active-low reset
//   addr    word address from the bridge; only addr[1:0] are decoded
//   we      write strobe
//   byteen  byte enables; only full-word writes take effect
//   wdata   write data
//   rdata   combinational read data for addr
//   irq     interrupt request (IM & irq_flag)

module timer_responder (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CNT,
      S_INT
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   state_t      state, state_nx;
   logic [3:0]  ctrl, ctrl_nx;
   logic [31:0] preset, preset_nx;
   logic [31:0] count, count_nx;
   logic        irq_flag, irq_flag_nx;

   logic        wr_full;
   logic [1:0]  sel;
   logic        unused_addr;

   assign sel         = addr[1:0];
   assign wr_full     = we && (byteen == 4'b1111);
   assign unused_addr = ^addr[29:2];

   always_comb begin
      rdata = 32'd0;
      case (sel)
         REG_CTRL:   rdata = {28'd0, ctrl};
         REG_PRESET: rdata = preset;
         REG_COUNT:  rdata = count;
         default:    rdata = 32'd0;
      endcase
   end

   assign irq = ctrl[3] & irq_flag;

   always_comb begin
      state_nx    = state;
      ctrl_nx     = ctrl;
      preset_nx   = preset;
      count_nx    = count;
      irq_flag_nx = irq_flag;

      case (state)
         S_IDLE: begin
            if (ctrl[0]) state_nx = S_LOAD;
         end
         S_LOAD: begin
            count_nx = preset;
            state_nx = S_CNT;
         end
         S_CNT: begin
            if (!ctrl[0]) begin
               state_nx = S_IDLE;
            end else if (count > 32'd1) begin
               count_nx = count - 32'd1;
            end else begin
               // A preset of 0 expires on the first counting cycle, like a preset of 1.
               count_nx    = 32'd0;
               irq_flag_nx = 1'b1;
               state_nx    = S_INT;
            end
         end
         S_INT: begin
            if (ctrl[2:1] == 2'b01) begin
               // Periodic: pulse ends here and the IDLE->LOAD path reloads.
               irq_flag_nx = 1'b0;
            end else begin
               // One-shot: stop the timer but leave the request pending.
               ctrl_nx[0] = 1'b0;
            end
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase

      // A bus write to CTRL restarts the timer and wins over the FSM; COUNT
      // keeps its current value at that edge.
      if (wr_full) begin
         case (sel)
            REG_CTRL: begin
               ctrl_nx     = wdata[3:0];
               state_nx    = S_IDLE;
               irq_flag_nx = 1'b0;
               count_nx    = count;
            end
            REG_PRESET: preset_nx = wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         state    <= state_nx;
         ctrl     <= ctrl_nx;
         preset   <= preset_nx;
         count    <= count_nx;
         irq_flag <= irq_flag_nx;
      end
   end

endmodule

// File: tb/tb_timer_responder.sv
// tb/tb_timer_responder.sv - self-checking bench for timer_responder

module tb_timer_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] addr;
   logic        we;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_chk = 0;
   int n_err = 0;

   timer_responder dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .we     (we),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   // Elapsed-time model: once armed, k counts edges since the arming edge.
   // The value loads at k=2, expiry (flag set) is at k=max(P,1)+2 and the
   // end-of-period action is one edge later.
   logic [3:0]  m_ctrl = 4'd0;
   logic [31:0] m_preset = 32'd0;
   logic [31:0] m_count = 32'd0;
   logic        m_flag = 1'b0;
   bit          m_armed = 1'b0;
   longint      m_k = 0;
   longint      m_load = 0;

   logic [3:0]  n_ctrl;
   logic [31:0] n_preset;
   logic [31:0] n_count;
   logic        n_flag;
   longint      m_exp;

   always @(posedge clk) begin
      if (!reset) begin
         m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
         m_armed = 1'b0; m_k = 0; m_load = 0;
      end else begin
         n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_flag = m_flag;
         if (m_armed) begin
            m_k = m_k + 1;
            if (m_k == 2) begin
               m_load  = longint'(m_preset);
               n_count = m_preset;
            end else if (m_k > 2) begin
               n_count = (m_load > m_k - 2) ? 32'(m_load - (m_k - 2)) : 32'd0;
            end
            m_exp = ((m_load == 0) ? 1 : m_load) + 2;
            if (m_k > 2 && m_k == m_exp) begin
               n_flag = 1'b1;
            end else if (m_k > 2 && m_k == m_exp + 1) begin
               if (m_ctrl[2:1] == 2'b01) begin
                  n_flag = 1'b0;
                  m_k    = 0;
               end else begin
                  n_ctrl[0] = 1'b0;
                  m_armed   = 1'b0;
               end
            end
         end
         if (we && byteen == 4'b1111) begin
            case (addr[1:0])
               2'd0: begin
                  n_ctrl  = wdata[3:0];
                  n_flag  = 1'b0;
                  n_count = m_count;
                  m_armed = wdata[0];
                  m_k     = 0;
               end
               2'd1: n_preset = wdata;
               default: ;
            endcase
         end
         m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_flag = n_flag;
      end
   end

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   // Per-cycle compare against the model.
   always @(posedge clk) begin
      #1;
      n_chk++;
      if (rdata !== model_rd(addr[1:0])) begin
         n_err++;
         $display("FAIL model_rdata t=%0t addr=%0d: got %h want %h", $time, addr[1:0], rdata, model_rd(addr[1:0]));
      end
      n_chk++;
      if (irq !== (m_ctrl[3] & m_flag)) begin
         n_err++;
         $display("FAIL model_irq t=%0t: got %b want %b", $time, irq, m_ctrl[3] & m_flag);
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      #1;
      addr = {28'd0, a}; wdata = d; byteen = be; we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0; byteen = 4'd0;
   endtask

   task automatic chk(input string nm, input logic [1:0] a, input logic [31:0] e);
      #1;
      addr = {28'd0, a};
      #1;
      n_chk++;
      if (rdata !== e) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, rdata, e);
      end
   endtask

   task automatic chk_irq(input string nm, input logic e);
      #1;
      n_chk++;
      if (irq !== e) begin
         n_err++;
         $display("FAIL %s: irq got %b want %b", nm, irq, e);
      end
   endtask

   initial begin
      // Reset with a concurrent CTRL write that must lose.
      reset = 1'b0; addr = 30'd0; we = 1'b1; byteen = 4'hF; wdata = 32'hF;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1; we = 1'b0; byteen = 4'd0;
      chk("rst_ctrl", 2'd0, 32'd0);
      chk("rst_preset", 2'd1, 32'd0);
      chk("rst_count", 2'd2, 32'd0);
      chk_irq("rst_irq", 1'b0);

      // One-shot, P=3.
      bus_wr(2'd1, 32'd3, 4'hF);
      bus_wr(2'd0, 32'h9, 4'hF);              // edge 0
      wait_edges(2); chk("os_cnt_e2", 2'd2, 32'd3);
      wait_edges(1); chk("os_cnt_e3", 2'd2, 32'd2);
      wait_edges(1); chk("os_cnt_e4", 2'd2, 32'd1); chk_irq("os_irq_e4", 1'b0);
      wait_edges(1); chk("os_cnt_e5", 2'd2, 32'd0); chk_irq("os_irq_e5", 1'b1);
      wait_edges(1); chk("os_ctrl_e6", 2'd0, 32'h8); chk_irq("os_irq_e6", 1'b1);
      wait_edges(3); chk("os_cnt_e9", 2'd2, 32'd0); chk_irq("os_irq_e9", 1'b1);

      // Periodic, P=3.
      bus_wr(2'd0, 32'hB, 4'hF);              // edge 0
      chk_irq("per_irq_clr", 1'b0);
      wait_edges(4); chk_irq("per_irq_e4", 1'b0);
      wait_edges(1); chk_irq("per_irq_e5", 1'b1);
      wait_edges(1); chk_irq("per_irq_e6", 1'b0);
      wait_edges(2); chk("per_cnt_e8", 2'd2, 32'd3);
      wait_edges(2); chk_irq("per_irq_e10", 1'b0);
      wait_edges(1); chk_irq("per_irq_e11", 1'b1);
      wait_edges(1); chk_irq("per_irq_e12", 1'b0); chk("per_ctrl_e12", 2'd0, 32'hB);
      bus_wr(2'd0, 32'h0, 4'hF);

      // Pending irq cleared by CTRL write; masked expiry; unmask clears flag.
      bus_wr(2'd0, 32'h9, 4'hF);
      wait_edges(5); chk_irq("pend_irq", 1'b1);
      bus_wr(2'd0, 32'h0, 4'hF); chk_irq("pend_clr", 1'b0);
      bus_wr(2'd0, 32'h1, 4'hF);
      wait_edges(6); chk_irq("mask_irq", 1'b0); chk("mask_ctrl", 2'd0, 32'h0);
      bus_wr(2'd0, 32'h8, 4'hF); chk_irq("unmask_irq", 1'b0);
      wait_edges(2); chk_irq("unmask_irq2", 1'b0);

      // P=0 expires like P=1.
      bus_wr(2'd1, 32'd0, 4'hF);
      bus_wr(2'd0, 32'h9, 4'hF);
      wait_edges(2); chk_irq("p0_irq_e2", 1'b0); chk("p0_cnt_e2", 2'd2, 32'd0);
      wait_edges(1); chk_irq("p0_irq_e3", 1'b1); chk("p0_cnt_e3", 2'd2, 32'd0);
      wait_edges(1); chk("p0_ctrl_e4", 2'd0, 32'h8);

      // Disable mid-count freezes COUNT.
      bus_wr(2'd1, 32'd10, 4'hF);
      bus_wr(2'd0, 32'h9, 4'hF);
      wait_edges(2); chk("frz_cnt_e2", 2'd2, 32'd10);
      wait_edges(4); chk("frz_cnt_e6", 2'd2, 32'd6);
      bus_wr(2'd0, 32'h8, 4'hF); chk("frz_cnt_e7", 2'd2, 32'd6);
      wait_edges(15); chk("frz_cnt_late", 2'd2, 32'd6); chk_irq("frz_irq", 1'b0);

      // Ignored writes and reserved register.
      bus_wr(2'd2, 32'h1234, 4'hF); chk("cnt_ro", 2'd2, 32'd6);
      bus_wr(2'd1, 32'hABCD, 4'b0011); chk("preset_partial", 2'd1, 32'd10);
      bus_wr(2'd0, 32'h9, 4'b0111); chk("ctrl_partial", 2'd0, 32'h8);
      bus_wr(2'd3, 32'hFFFF_FFFF, 4'hF); chk("rsvd_rd", 2'd3, 32'd0);

      // Reset mid-count.
      bus_wr(2'd0, 32'h9, 4'hF);
      wait_edges(4);
      reset = 1'b0;
      wait_edges(1);
      reset = 1'b1;
      chk("rst2_count", 2'd2, 32'd0);
      chk("rst2_ctrl", 2'd0, 32'd0);
      chk("rst2_preset", 2'd1, 32'd0);
      wait_edges(3); chk("rst2_idle", 2'd2, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
